tinyqv_spi_ctrl: RTL and testbench

Byte-oriented SPI controller peripheral for tinyQV that produces the display/SPI pins on `uo_out` (`spi_cs` = `uo_out[4]`, `spi_sck` = `uo_out[5]`, `spi_mosi` = `uo_out[3]`, `spi_dc` = `uo_out[2]`) and samples `spi_miso` from `ui_in[2]`.

The CPU peripheral bus writes a byte plus DC/end-of-transaction flags. The block shifts the byte out in SPI mode 0 at a programmable rate while capturing MISO. It then reports completion through `busy` and returns the received byte on `data_out`.

---
 rtl/tinyqv_spi_ctrl.sv | 151 +++++++++++++++
 tb/tb_tinyqv_spi_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_spi_ctrl.sv
// tinyqv_spi_ctrl: byte-oriented SPI mode-0 controller.
// Shifts one byte out MSB-first at a programmable SCK rate and captures MISO.
// All outputs are registered.
`timescale 1ns/1ps

module tinyqv_spi_ctrl #(
    parameter int unsigned DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           data_in,
    input  logic                 dc_in,
    input  logic                 end_txn,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 read_latency,
    input  logic                 spi_miso,
    output logic                 busy,
    output logic [7:0]           data_out,
    output logic                 spi_select,
    output logic                 spi_clk_out,
    output logic                 spi_data_out,
    output logic                 spi_dc
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           rx_q, rx_d;
    logic [2:0]           bit_q, bit_d;
    logic [DIV_WIDTH-1:0] half_q, half_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 end_q, end_d;
    logic                 busy_d;
    logic [7:0]           data_out_d;
    logic                 select_d;
    logic                 sck_d;
    logic                 mosi_d;
    logic                 dc_d;
    logic [7:0]           rx_shift;

    assign rx_shift = {rx_q[6:0], spi_miso};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic; every half period ends with an SCK edge.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        half_d     = half_q;
        div_d      = div_q;
        end_d      = end_q;
        busy_d     = busy;
        data_out_d = data_out;
        select_d   = spi_select;
        sck_d      = spi_clk_out;
        mosi_d     = spi_data_out;
        dc_d       = spi_dc;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    tx_d     = data_in;
                    rx_d     = 8'h00;
                    bit_d    = 3'd0;
                    half_d   = '0;
                    div_d    = divider;
                    end_d    = end_txn;
                    busy_d   = 1'b1;
                    select_d = 1'b0;
                    sck_d    = 1'b0;
                    mosi_d   = data_in[7];
                    dc_d     = dc_in;
                end
            end
            SHIFT: begin
                if (half_q == div_q) begin
                    half_d = '0;
                    if (!spi_clk_out) begin
                        sck_d = 1'b1;
                        if (!read_latency) begin
                            rx_d = rx_shift;
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (read_latency) begin
                            rx_d = rx_shift;
                        end
                        if (bit_q == 3'd7) begin
                            state_d    = IDLE;
                            busy_d     = 1'b0;
                            data_out_d = read_latency ? rx_shift : rx_q;
                            select_d   = end_q;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
                        end
                    end
                end else begin
                    half_d = half_q + DIV_WIDTH'(1);
                end
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q         <= 8'h00;
            rx_q         <= 8'h00;
            bit_q        <= 3'd0;
            half_q       <= '0;
            div_q        <= '0;
            end_q        <= 1'b0;
            busy         <= 1'b0;
            data_out     <= 8'h00;
            spi_select   <= 1'b1;
            spi_clk_out  <= 1'b0;
            spi_data_out <= 1'b0;
            spi_dc       <= 1'b0;
        end else begin
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bit_q        <= bit_d;
            half_q       <= half_d;
            div_q        <= div_d;
            end_q        <= end_d;
            busy         <= busy_d;
            data_out     <= data_out_d;
            spi_select   <= select_d;
            spi_clk_out  <= sck_d;
            spi_data_out <= mosi_d;
            spi_dc       <= dc_d;
        end
    end

endmodule

// File: tb/tb_tinyqv_spi_ctrl.sv
// Testbench for tinyqv_spi_ctrl: directed and random byte transfers against a
// mode-0 slave model, with expected MISO capture derived from timing arithmetic.
`timescale 1ns/1ps

module tb_tinyqv_spi_ctrl;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    data_in;
    logic          dc_in;
    logic          end_txn;
    logic [DW-1:0] divider;
    logic          read_latency;
    logic          spi_miso;
    logic          busy;
    logic [7:0]    data_out;
    logic          spi_select;
    logic          spi_clk_out;
    logic          spi_data_out;
    logic          spi_dc;

    int checks = 0;
    int errors = 0;

    tinyqv_spi_ctrl #(.DIV_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_in      (data_in),
        .dc_in        (dc_in),
        .end_txn      (end_txn),
        .divider      (divider),
        .read_latency (read_latency),
        .spi_miso     (spi_miso),
        .busy         (busy),
        .data_out     (data_out),
        .spi_select   (spi_select),
        .spi_clk_out  (spi_clk_out),
        .spi_data_out (spi_data_out),
        .spi_dc       (spi_dc)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: presents bit (7 - falls) and advances on each SCK fall,
    // with its MISO output delayed by delay_n clocks.
    logic [7:0] slave_byte = 8'h00;
    int         delay_n    = 0;
    logic [7:0] hist       = 8'h00;
    int         falls      = 0;
    logic       sck_prev   = 1'b0;

    always @(negedge clk) begin
        if (spi_select === 1'b1) falls = 0;
        else if (sck_prev && !spi_clk_out) falls = falls + 1;
        sck_prev = spi_clk_out;
        hist     = {hist[6:0], slave_byte[7 - (falls % 8)]};
        spi_miso = hist[delay_n];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected RX byte: bit i is sampled at clock edge (2i+1)(D+1) or (2i+2)(D+1)
    // after the start edge; MISO then reflects the slave's bit index at time ts-1-n.
    function automatic logic [7:0] model_rx(input logic [7:0] sb, input int d,
                                            input bit rl, input int n);
        logic [7:0] r;
        int ts, k;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ts = rl ? (2 * i + 2) * (d + 1) : (2 * i + 1) * (d + 1);
            k  = ts - 1 - n;
            k  = (k < 0) ? 0 : k / (2 * (d + 1));
            if (k > 7) k = 7;
            r[7 - i] = sb[7 - k];
        end
        return r;
    endfunction

    task automatic setup_slave(input logic [7:0] sb, input int n, input bit rl);
        slave_byte   = sb;
        delay_n      = n;
        read_latency = rl;
        repeat (4) @(negedge clk);
    endtask

    // Pulse start for one clock, then scramble the per-byte inputs.
    task automatic start_byte(input logic [7:0] d8, input bit dc, input bit et, input int dv);
        data_in = d8;
        dc_in   = dc;
        end_txn = et;
        divider = DW'(dv);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'($urandom);
        dc_in   = ~dc;
        end_txn = ~et;
        divider = DW'($urandom);
    endtask

    // Observe one byte from the cycle after the start edge until busy drops.
    task automatic watch_byte(input string tag, input logic [7:0] d8, input bit dc,
                              input bit et, input int dv, input bit rl,
                              input logic [7:0] sb, input int n, input int glitch_at);
        int         cyc        = 0;
        int         rises      = 0;
        int         first_rise = -1;
        int         dc_bad     = 0;
        int         cs_bad     = 0;
        logic [7:0] mosi_cap   = 8'h00;
        logic       prev       = 1'b0;
        check($sformatf("%s start_busy", tag), 32'(busy), 32'd1);
        check($sformatf("%s start_cs", tag), 32'(spi_select), 32'd0);
        check($sformatf("%s start_mosi", tag), 32'(spi_data_out), 32'(d8[7]));
        while (busy === 1'b1 && cyc < 400) begin
            if (spi_clk_out && !prev) begin
                mosi_cap = {mosi_cap[6:0], spi_data_out};
                rises++;
                if (first_rise < 0) first_rise = cyc;
            end
            prev = spi_clk_out;
            if (spi_dc !== dc) dc_bad++;
            if (spi_select !== 1'b0) cs_bad++;
            if (cyc == glitch_at) begin
                data_in = 8'hFF;
                start   = 1'b1;
            end else begin
                start   = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("%s busy_len", tag), 32'(cyc), 32'(16 * (dv + 1)));
        check($sformatf("%s first_rise", tag), 32'(first_rise), 32'(dv + 1));
        check($sformatf("%s rises", tag), 32'(rises), 32'd8);
        check($sformatf("%s mosi_bits", tag), 32'(mosi_cap), 32'(d8));
        check($sformatf("%s dc_stable", tag), 32'(dc_bad), 32'd0);
        check($sformatf("%s cs_low", tag), 32'(cs_bad), 32'd0);
        check($sformatf("%s data_out", tag), 32'(data_out), 32'(model_rx(sb, dv, rl, n)));
        check($sformatf("%s end_cs", tag), 32'(spi_select), 32'(et));
        check($sformatf("%s end_sck", tag), 32'(spi_clk_out), 32'd0);
        check($sformatf("%s mosi_hold", tag), 32'(spi_data_out), 32'(d8[0]));
        check($sformatf("%s dc_hold", tag), 32'(spi_dc), 32'(dc));
    endtask

    initial begin
        logic [7:0] rd, rsb;
        int         rdv, rn;
        bit         rdc, ret, rrl;
        int         guard;

        rst_n        = 1'b0;
        start        = 1'b0;
        data_in      = 8'h00;
        dc_in        = 1'b0;
        end_txn      = 1'b0;
        divider      = '0;
        read_latency = 1'b0;
        spi_miso     = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        check("rst cs", 32'(spi_select), 32'd1);
        check("rst sck", 32'(spi_clk_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst data_out", 32'(data_out), 32'h00);
        check("rst mosi", 32'(spi_data_out), 32'd0);
        check("rst dc", 32'(spi_dc), 32'd0);
        rst_n = 1'b1;

        // D=0, 0xA5 out, 0x3C back, sampled on SCK rise.
        setup_slave(8'h3C, 0, 1'b0);
        start_byte(8'hA5, 1'b1, 1'b1, 0);
        watch_byte("a5", 8'hA5, 1'b1, 1'b1, 0, 1'b0, 8'h3C, 0, -1);
        check("a5 literal", 32'(data_out), 32'h3C);

        // D=3 back-to-back bytes, CS held low across the boundary.
        setup_slave(8'h69, 0, 1'b0);
        start_byte(8'h12, 1'b0, 1'b0, 3);
        watch_byte("b2b0", 8'h12, 1'b0, 1'b0, 3, 1'b0, 8'h69, 0, -1);
        start_byte(8'h34, 1'b1, 1'b1, 3);
        watch_byte("b2b1", 8'h34, 1'b1, 1'b1, 3, 1'b0, 8'h69, 0, -1);

        // Delayed slave: falling-edge sampling tolerates the delay.
        setup_slave(8'hC3, 1, 1'b1);
        start_byte(8'h5A, 1'b0, 1'b1, 1);
        watch_byte("rl1", 8'h5A, 1'b0, 1'b1, 1, 1'b1, 8'hC3, 1, -1);
        check("rl1 literal", 32'(data_out), 32'hC3);
        setup_slave(8'hC3, 1, 1'b0);
        start_byte(8'h5A, 1'b0, 1'b1, 1);
        watch_byte("rl0d1", 8'h5A, 1'b0, 1'b1, 1, 1'b0, 8'hC3, 1, -1);
        check("rl0d1 literal", 32'(data_out), 32'hC3);
        setup_slave(8'hC3, 2, 1'b0);
        start_byte(8'h5A, 1'b0, 1'b1, 1);
        watch_byte("rl0d2", 8'h5A, 1'b0, 1'b1, 1, 1'b0, 8'hC3, 2, -1);
        check("rl0d2 literal", 32'(data_out), 32'hE1);

        // start re-asserted mid-byte with 0xFF is ignored.
        setup_slave(8'h0F, 0, 1'b0);
        start_byte(8'h96, 1'b1, 1'b1, 2);
        watch_byte("glitch", 8'h96, 1'b1, 1'b1, 2, 1'b0, 8'h0F, 0, 10);

        // Reset after 3 SCK rises, then a clean 0x81 transfer.
        setup_slave(8'hA7, 0, 1'b0);
        start_byte(8'h5A, 1'b1, 1'b0, 1);
        guard = 0;
        begin
            int   r  = 0;
            logic pv = 1'b0;
            while (r < 3 && guard < 200) begin
                if (spi_clk_out && !pv) r++;
                pv = spi_clk_out;
                guard++;
                if (r < 3) @(negedge clk);
            end
            check("mid rises_reached", 32'(r), 32'd3);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid cs", 32'(spi_select), 32'd1);
        check("mid busy", 32'(busy), 32'd0);
        check("mid sck", 32'(spi_clk_out), 32'd0);
        check("mid mosi", 32'(spi_data_out), 32'd0);
        check("mid dc", 32'(spi_dc), 32'd0);
        check("mid data_out", 32'(data_out), 32'h00);
        rst_n = 1'b1;
        setup_slave(8'h3D, 0, 1'b0);
        start_byte(8'h81, 1'b0, 1'b1, 1);
        watch_byte("post", 8'h81, 1'b0, 1'b1, 1, 1'b0, 8'h3D, 0, -1);

        // Random transfers.
        for (int t = 0; t < 12; t++) begin
            rd  = 8'($urandom);
            rsb = 8'($urandom);
            rdv = int'($urandom_range(0, 3));
            rn  = int'($urandom_range(0, 3));
            rdc = 1'($urandom);
            ret = 1'($urandom);
            rrl = 1'($urandom);
            setup_slave(rsb, rn, rrl);
            start_byte(rd, rdc, ret, rdv);
            watch_byte($sformatf("rnd%0d", t), rd, rdc, ret, rdv, rrl, rsb, rn, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
